rr_arbiter_4x2: RTL
===================

# rr_arbiter_4x2

Four-requester round-robin arbiter that shares a single downstream resource (encoder datapath, bus or port) among four clients. It accepts a 4-bit request vector and issues a registered one-hot grant together with its 2-bit encoded index and a valid flag, matching the `{y, v}` output convention of the team's 4:2 encoders. It holds each grant until the owner finishes or a hold timeout expires, then rotates priority so that no requester starves.

## Interface
Parameters:
- `MAX_HOLD`, 16: maximum cycles a grant may be held before forced release; legal range 1..255.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset; release is synchronous to `clk` externally.
- `req`  in  4  request vector; `req[k]` high means client k wants the resource; held high until served.
- `done`  in  1  owner-finished pulse; sampled only while `v` = 1.
- `gnt`  out  4  one-hot grant, registered; all zero when no grant.
- `y`  out  2  encoded index of the granted client; 0 when `v` = 0.
- `v`  out  1  grant valid; equals OR of `gnt`.
- `timeout`  out  1  one-cycle pulse when a grant is forcibly released by the hold limit.

## Operation
- State machine has two states, IDLE and GRANT. Reset enters IDLE.
- Priority pointer `ptr[1:0]`: the highest-priority client. Reset value is 0.
- IDLE:
  - If `req` = 0, remain in IDLE.
  - Otherwise, select the first set bit of `req` scanning `ptr`, `ptr+1`, … mod 4.
  - Next edge: enter GRANT, set `gnt`/`y` to the winner, `v` = 1, `hold_cnt` = 0.
- GRANT: on each edge, `hold_cnt` increments (8-bit, saturating not needed because the range is bounded). Release occurs when any of the following is true in the current cycle:
  - `done` = 1
  - `req[y]` = 0 (requester withdrew)
  - `hold_cnt` == `MAX_HOLD`-1
- Release: on the next edge, go to IDLE, set `gnt` = 0, `y` = 0, `v` = 0, and `ptr` = `y`+1 mod 4 (wrap 3→0).
- `timeout` = 1 for that one cycle only when the release was caused solely by the hold limit. If `done` or a withdrawn request coincides with the limit, `timeout` stays 0.
- Requests from non-owners during GRANT are ignored; they are arbitrated in the following IDLE cycle using the updated `ptr`.
- `done` while in IDLE is ignored.
- `gnt` is never multi-hot. `y` always equals the encoded `gnt`.

## Timing
- Reset values: `gnt` = 0000, `y` = 00, `v` = 0, `timeout` = 0, `ptr` = 0, `hold_cnt` = 0, state IDLE.
- Reset is asynchronous. Asserting `rst_n` mid-grant drops `gnt`/`v` immediately, without waiting for an edge.
- Request-to-grant latency: 1 cycle. A `req` sampled at edge N in IDLE produces `gnt` valid after edge N.
- Minimum grant length: 1 cycle (`done` in the first GRANT cycle).
- Maximum grant length: `MAX_HOLD` cycles.
- Minimum gap between consecutive grants: exactly 1 IDLE cycle with `v` = 0.
- All outputs are registered; there are no combinational paths from `req` or `done` to outputs.

## Test plan
- Reset/idle: assert `rst_n` = 0, then release with `req` = 0000 → `gnt` = 0000, `y` = 00, `v` = 0, `timeout` = 0 for 10 cycles.
- Single request: `req` = 0100, `done` pulse 3 cycles after the grant → `gnt` = 0100, `y` = 10, `v` = 1 for 3 cycles. Next cycle `v` = 0, `ptr` = 3.
- Round-robin rotation: `req` = 1111 held, `done` each grant cycle → grant order 0, 1, 2, 3, 0 with `y` = 00, 01, 10, 11, 00, one IDLE cycle between each.
- Timeout: `MAX_HOLD` = 4, `req` = 0010 held, no `done` → `gnt` = 0010 for exactly 4 cycles, `timeout` pulses 1 cycle, then `gnt` = 0000. Re-grant to client 1 follows after one IDLE cycle. Also check `done` at cycle 4 → `timeout` = 0.
- Withdrawal and wrap: grant client 3, drop `req[3]` with `req` = 0001 pending → release, `ptr` wraps to 0, client 0 granted (`y` = 00) two cycles after the drop.
- Async reset mid-grant: `rst_n` falls while `gnt` = 1000 → `gnt` = 0000 and `v` = 0 before the next edge. After reset, `req` = 1010 grants client 1 (`ptr` back to 0).

Source files
------------

// File: rtl/rr_arbiter_4x2.sv
// rr_arbiter_4x2: four-client round-robin arbiter with hold timeout, registered one-hot grant plus {y, v} encoding
module rr_arbiter_4x2 #(
    parameter int MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic       done,
    output logic [3:0] gnt,
    output logic [1:0] y,
    output logic       v,
    output logic       timeout
);
    typedef enum logic {IDLE, GRANT} state_t;
    state_t state, state_nxt;
    logic [1:0] ptr, win;
    logic [7:0] hold_cnt;
    logic lim, rel;
    assign lim = hold_cnt == 8'(MAX_HOLD - 1);
    assign rel = done | ~req[y] | lim;
    // winner: first requester at or after ptr, scanning upward modulo 4
    always_comb begin
        win = ptr;
        for (int i = 3; i >= 0; i--)
            if (req[2'(ptr + 2'(i))]) win = 2'(ptr + 2'(i));
    end
    // state register
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else state <= state_nxt;
    // next state: grab on any request, drop on done, withdrawal or hold limit
    always_comb
        state_nxt = state == IDLE ? (|req ? GRANT : IDLE) : (rel ? IDLE : GRANT);
    // owner index, priority pointer, hold counter and timeout pulse
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            y        <= 2'd0;
            ptr      <= 2'd0;
            hold_cnt <= 8'd0;
            timeout  <= 1'b0;
        end else begin
            timeout <= state == GRANT && lim && !done && req[y];
            if (state == IDLE) begin
                hold_cnt <= 8'd0;
                if (|req) y <= win;
            end else if (rel) begin
                y        <= 2'd0;
                ptr      <= y + 2'd1;
                hold_cnt <= 8'd0;
            end else hold_cnt <= hold_cnt + 8'd1;
        end
    // outputs decode only from flops, so nothing combinational reaches them from req or done
    always_comb begin
        v   = state == GRANT;
        gnt = v ? 4'(1) << y : 4'd0;
    end
endmodule
